toll_booth_ctrl: RTL

Sequencing controller for one toll lane. It detects an arriving vehicle and latches the four traffic-condition flags into the combinational rate classifier. After a fixed settle window it samples the classifier's H/M/L/E outputs and maps the rate to a fee, then collects coins, returns change and operates the gate. It sits between lane sensors/coin acceptor and the rate classifier; the classifier's 16-unit propagation delay is covered by the settle window.

---
 rtl/toll_booth_ctrl_pkg.sv | 29 ++
 rtl/toll_booth_ctrl_if.sv | 22 ++
 rtl/toll_booth_ctrl_pay_accum.sv | 78 +++++++
 rtl/toll_booth_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/toll_booth_ctrl_pkg.sv
// Shared types and defaults for the toll lane controller: FSM states,
// default fees, coin width and the classifier result check.
package toll_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CHECK   = 3'd2,
        COLLECT = 3'd3,
        GATE    = 3'd4,
        ERROR   = 3'd5
    } toll_state_e;

    localparam int FEE_H_DEF      = 12;
    localparam int FEE_M_DEF      = 8;
    localparam int FEE_L_DEF      = 4;
    localparam int SETTLE_CYC_DEF = 2;
    localparam int AW_DEF         = 8;
    localparam int COIN_W         = 4;

    // A usable rate is exactly one of H/M/L with no error; E overrides everything.
    function automatic logic rate_is_valid(input logic h, input logic m,
                                           input logic l, input logic e);
        logic [2:0] w_hml;
        w_hml = {h, m, l};
        return (!e) && ((w_hml == 3'b100) || (w_hml == 3'b010) || (w_hml == 3'b001));
    endfunction

endpackage

// File: rtl/toll_booth_ctrl_if.sv
// Coin acceptor / change dispenser bundle between the lane hardware (master)
// and the toll controller (slave).
interface toll_booth_ctrl_if #(
    parameter int AW = 8
);
    logic                       coin_valid;
    logic [toll_pkg::COIN_W-1:0] coin_value;
    logic                       coin_ready;
    logic [AW-1:0]              fee_due;
    logic                       change_valid;
    logic [AW-1:0]              change_amt;

    modport master (
        output coin_valid, coin_value,
        input  coin_ready, fee_due, change_valid, change_amt
    );

    modport slave (
        input  coin_valid, coin_value,
        output coin_ready, fee_due, change_valid, change_amt
    );
endinterface

// File: rtl/toll_booth_ctrl_pay_accum.sv
// Payment accumulator: holds fee and paid amount, compares them and produces
// the change / refund strobe. Fees must satisfy max fee + 15 < 2**AW.
module toll_pay_accum
    import toll_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [AW-1:0]     i_fee,
    input  logic              i_collect,
    input  logic              i_coin_en,
    input  logic [COIN_W-1:0] i_coin_value,
    input  logic              i_abort,
    output logic              o_paid_done,
    output logic [AW-1:0]     o_fee_due,
    output logic              o_change_valid,
    output logic [AW-1:0]     o_change_amt
);
    logic [AW-1:0] r_fee;
    logic [AW-1:0] r_paid;
    logic [AW-1:0] r_fee_due;
    logic [AW-1:0] r_change_amt;
    logic          r_change_valid;
    logic [AW-1:0] w_coin_add;
    logic [AW-1:0] w_paid_next;

    // Paid amount including this cycle's coin, so a same-cycle abort refunds it too.
    always_comb begin
        w_coin_add = {AW{1'b0}};
        if (i_coin_en) begin
            w_coin_add = AW'(i_coin_value);
        end else begin
            w_coin_add = {AW{1'b0}};
        end
        w_paid_next = r_paid + w_coin_add;
    end

    assign o_paid_done = (w_paid_next >= r_fee);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fee          <= {AW{1'b0}};
            r_paid         <= {AW{1'b0}};
            r_fee_due      <= {AW{1'b0}};
            r_change_amt   <= {AW{1'b0}};
            r_change_valid <= 1'b0;
        end else if (i_load) begin
            r_fee          <= i_fee;
            r_paid         <= {AW{1'b0}};
            r_fee_due      <= i_fee;
            r_change_valid <= 1'b0;
        end else if (i_collect) begin
            r_paid <= w_paid_next;
            if (i_abort) begin
                r_change_valid <= (w_paid_next != {AW{1'b0}});
                r_change_amt   <= w_paid_next;
                r_fee_due      <= {AW{1'b0}};
            end else if (o_paid_done) begin
                r_change_valid <= 1'b1;
                r_change_amt   <= w_paid_next - r_fee;
                r_fee_due      <= {AW{1'b0}};
            end else begin
                r_change_valid <= 1'b0;
                r_fee_due      <= r_fee - w_paid_next;
            end
        end else begin
            r_change_valid <= 1'b0;
            r_fee_due      <= {AW{1'b0}};
        end
    end

    assign o_fee_due      = r_fee_due;
    assign o_change_valid = r_change_valid;
    assign o_change_amt   = r_change_amt;

endmodule

// File: rtl/toll_booth_ctrl.sv
// Toll lane sequencer: latches condition flags for the rate classifier, waits
// for it to settle, maps the rate to a fee, collects payment and drives the gate.
module toll_booth_ctrl
    import toll_pkg::*;
#(
    parameter int FEE_H      = FEE_H_DEF,
    parameter int FEE_M      = FEE_M_DEF,
    parameter int FEE_L      = FEE_L_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               car_present,
    input  logic               wd_in,
    input  logic               rh_in,
    input  logic               ln_in,
    input  logic               ht_in,
    output logic               cls_wd,
    output logic               cls_rh,
    output logic               cls_ln,
    output logic               cls_ht,
    input  logic               rate_h,
    input  logic               rate_m,
    input  logic               rate_l,
    input  logic               rate_e,
    toll_booth_ctrl_if.slave   pay_if,
    output logic               gate_open,
    output logic               err_alarm,
    input  logic               err_ack,
    output logic               busy
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    toll_state_e      r_state;
    toll_state_e      w_next;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             r_armed;
    logic [3:0]       r_cls;
    logic             r_coin_ready;
    logic             r_gate_open;
    logic             r_err_alarm;
    logic             r_busy;
    logic             w_latch;
    logic             w_load;
    logic [AW-1:0]    w_fee_sel;
    logic             w_collect;
    logic             w_coin_en;
    logic             w_paid_done;
    logic [AW-1:0]    w_fee_due;
    logic             w_change_valid;
    logic [AW-1:0]    w_change_amt;

    assign w_collect = (r_state == COLLECT);
    assign w_coin_en = w_collect && pay_if.coin_valid;

    // Next-state and control decode; fee chosen while the classifier result is sampled.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_load    = 1'b0;
        w_fee_sel = {AW{1'b0}};
        case (r_state)
            IDLE: begin
                if (car_present && r_armed) begin
                    w_next  = SETTLE;
                    w_latch = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == CNT_LAST) begin
                    w_next = CHECK;
                end else begin
                    w_next = SETTLE;
                end
            end
            CHECK: begin
                if (rate_is_valid(rate_h, rate_m, rate_l, rate_e)) begin
                    w_next = COLLECT;
                    w_load = 1'b1;
                    if (rate_h) begin
                        w_fee_sel = AW'(FEE_H);
                    end else if (rate_m) begin
                        w_fee_sel = AW'(FEE_M);
                    end else begin
                        w_fee_sel = AW'(FEE_L);
                    end
                end else begin
                    w_next = ERROR;
                end
            end
            COLLECT: begin
                if (!car_present) begin
                    w_next = IDLE;
                end else if (w_paid_done) begin
                    w_next = GATE;
                end else begin
                    w_next = COLLECT;
                end
            end
            GATE: begin
                if (!car_present) begin
                    w_next = IDLE;
                end else begin
                    w_next = GATE;
                end
            end
            ERROR: begin
                if (err_ack && !car_present) begin
                    w_next = IDLE;
                end else begin
                    w_next = ERROR;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= {CNT_W{1'b0}};
        end else if (r_state == SETTLE) begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
        end else begin
            r_settle_cnt <= {CNT_W{1'b0}};
        end
    end

    // A vehicle is only recognised after the lane has been seen empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else if (!car_present) begin
            r_armed <= 1'b1;
        end else if (w_latch) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= r_armed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cls <= 4'b0000;
        end else if (w_latch) begin
            r_cls <= {wd_in, rh_in, ln_in, ht_in};
        end else begin
            r_cls <= r_cls;
        end
    end

    // Outputs registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin_ready <= 1'b0;
            r_gate_open  <= 1'b0;
            r_err_alarm  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_coin_ready <= (w_next == COLLECT);
            r_gate_open  <= (w_next == GATE);
            r_err_alarm  <= (w_next == ERROR);
            r_busy       <= (w_next != IDLE);
        end
    end

    toll_pay_accum #(
        .AW (AW)
    ) u_pay_accum (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_load         (w_load),
        .i_fee          (w_fee_sel),
        .i_collect      (w_collect),
        .i_coin_en      (w_coin_en),
        .i_coin_value   (pay_if.coin_value),
        .i_abort        (!car_present),
        .o_paid_done    (w_paid_done),
        .o_fee_due      (w_fee_due),
        .o_change_valid (w_change_valid),
        .o_change_amt   (w_change_amt)
    );

    assign {cls_wd, cls_rh, cls_ln, cls_ht} = r_cls;
    assign pay_if.coin_ready   = r_coin_ready;
    assign pay_if.fee_due      = w_fee_due;
    assign pay_if.change_valid = w_change_valid;
    assign pay_if.change_amt   = w_change_amt;
    assign gate_open           = r_gate_open;
    assign err_alarm           = r_err_alarm;
    assign busy                = r_busy;

endmodule
